// File: rtl/apb_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : apb_sampler
// Brief   : Periodically captures a 32-bit word and writes it to one APB
//           slave register, then reads it back to confirm. Slave errors and
//           read-back mismatches trigger a bounded number of write retries.
// Rev     : 1.0  initial release
// ============================================================================
module apb_sampler #(
  parameter int unsigned PERIOD    = 50,
  parameter logic [7:0]  ADDR      = 8'h00,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic [31:0] pdata_i,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic [7:0]  paddr_o,
  output logic [31:0] pwdata_o,
  output logic        pwrite_o
);

  localparam int unsigned        c_CNT_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned        c_RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);
  localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_ACCESS = 3'd2,
    S_R_SETUP  = 3'd3,
    S_R_ACCESS = 3'd4
  } state_t;

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_tick;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_sample;
  logic [31:0]        w_sample_nxt;
  logic               r_pending;
  logic [c_RTY_W-1:0] r_retry;
  logic               w_retry_ok;
  logic               w_retry;

  assign w_tick       = (r_cnt == c_CNT_LAST);
  // A write setup entered on a tick edge must carry the word latched on that edge.
  assign w_sample_nxt = w_tick ? pdata_i : r_sample;
  assign w_retry_ok   = (r_retry < c_RTY_MAX);

  // Free-running sample-interval counter; the tick is its last count.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Next-state decision; completion responses only count when pready_i is high in an access state.
  always_comb begin
    w_state_nxt = r_state;
    w_retry     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick || r_pending) w_state_nxt = S_W_SETUP;
      end
      S_W_SETUP: w_state_nxt = S_W_ACCESS;
      S_W_ACCESS: begin
        if (pready_i) begin
          if (!pslverr_i) begin
            w_state_nxt = S_R_SETUP;
          end else if (w_retry_ok) begin
            w_state_nxt = S_W_SETUP;
            w_retry     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_R_SETUP: w_state_nxt = S_R_ACCESS;
      S_R_ACCESS: begin
        if (pready_i) begin
          if (!pslverr_i && (prdata_i == r_sample)) begin
            w_state_nxt = S_IDLE;
          end else if (w_retry_ok) begin
            w_state_nxt = S_W_SETUP;
            w_retry     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, sample/pending bookkeeping and registered bus outputs driven from the next state.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      r_state   <= S_IDLE;
      r_sample  <= '0;
      r_pending <= 1'b0;
      r_retry   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= 8'h00;
      pwdata_o  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tick) r_sample <= pdata_i;

      if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
        r_retry   <= '0;
      end else begin
        // Ticks while busy collapse into one pending request.
        if (w_tick)  r_pending <= 1'b1;
        if (w_retry) r_retry   <= r_retry + c_RTY_W'(1);
      end

      case (w_state_nxt)
        S_W_SETUP: begin
          psel_o    <= 1'b1;
          penable_o <= 1'b0;
          pwrite_o  <= 1'b1;
          paddr_o   <= ADDR;
          pwdata_o  <= w_sample_nxt;
        end
        S_W_ACCESS: begin
          psel_o    <= 1'b1;
          penable_o <= 1'b1;
          pwrite_o  <= 1'b1;
          paddr_o   <= ADDR;
        end
        S_R_SETUP: begin
          psel_o    <= 1'b1;
          penable_o <= 1'b0;
          pwrite_o  <= 1'b0;
          paddr_o   <= ADDR;
        end
        S_R_ACCESS: begin
          psel_o    <= 1'b1;
          penable_o <= 1'b1;
          pwrite_o  <= 1'b0;
          paddr_o   <= ADDR;
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_apb_sampler
// Brief   : Two apb_sampler instances (default PERIOD=50, and PERIOD=4 with
//           long waits) driven by a randomized slave script. A transaction-
//           level timeline predicts every bus cycle from the sampling rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_apb_sampler;

  localparam int         N  = 1200;
  localparam int         NE = N + 80;
  localparam int         P0 = 50;
  localparam int         P1 = 4;
  localparam int         R0 = 2;
  localparam int         R1 = 1;
  localparam logic [7:0] A0 = 8'h00;
  localparam logic [7:0] A1 = 8'hA5;
  localparam logic [42:0] M_FULL = '1;
  localparam logic [42:0] M_IDLE = {3'b110, 8'h00, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s0_pdata, s0_prdata, s0_pwdata, s1_pdata, s1_prdata, s1_pwdata;
  logic        s0_pready, s0_pslverr, s0_psel, s0_penable, s0_pwrite;
  logic        s1_pready, s1_pslverr, s1_psel, s1_penable, s1_pwrite;
  logic [7:0]  s0_paddr, s1_paddr;

  apb_sampler #(.PERIOD(P0), .ADDR(A0), .MAX_RETRY(R0)) dut0 (
    .pclk_i(clk), .preset_i(rst), .pdata_i(s0_pdata), .prdata_i(s0_prdata),
    .pready_i(s0_pready), .pslverr_i(s0_pslverr), .psel_o(s0_psel),
    .penable_o(s0_penable), .paddr_o(s0_paddr), .pwdata_o(s0_pwdata), .pwrite_o(s0_pwrite)
  );

  apb_sampler #(.PERIOD(P1), .ADDR(A1), .MAX_RETRY(R1)) dut1 (
    .pclk_i(clk), .preset_i(rst), .pdata_i(s1_pdata), .prdata_i(s1_prdata),
    .pready_i(s1_pready), .pslverr_i(s1_pslverr), .psel_o(s1_psel),
    .penable_o(s1_penable), .paddr_o(s1_paddr), .pwdata_o(s1_pwdata), .pwrite_o(s1_pwrite)
  );

  int checks = 0;
  int errors = 0;
  int obs_w0 = 0;
  int obs_w1 = 0;

  // Script and prediction, indexed by the rising edge (counted from reset release).
  logic [42:0] exp_v [2][NE];
  logic [42:0] exp_m [2][NE];
  bit          pr_e  [2][NE];
  bit          er_e  [2][NE];
  bit          wc_e  [2][NE];
  logic [31:0] rd_e  [2][NE];
  logic [31:0] pd_e  [2][NE];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [42:0] pk(input logic sel, input logic en, input logic wr,
                                     input logic [7:0] a, input logic [31:0] d);
    return {sel, en, wr, a, d};
  endfunction

  function automatic logic [42:0] obs(input int k);
    if (k == 0) return pk(s0_psel, s0_penable, s0_pwrite, s0_paddr, s0_pwdata);
    return pk(s1_psel, s1_penable, s1_pwrite, s1_paddr, s1_pwdata);
  endfunction

  // Word held by the sampler after edge e: the pdata_i seen on the latest tick at or before e.
  function automatic logic [31:0] samp_at(input int k, input int per, input int e);
    int t;
    t = (e / per) * per;
    if (t < per) return 32'h0;
    return pd_e[k][t];
  endfunction

  // Build the slave script and the expected bus timeline, one transaction at a time.
  task automatic gen(input int k, input int per, input int maxr, input logic [7:0] addr);
    int s, s0, e_end, cw, cr, ws, wr, retries, j, mode;
    bit werr, rerr, done, pend;
    logic [31:0] wd, rd, reg_v, last_wd;
    for (int e = 0; e < NE; e++) begin
      pr_e[k][e] = ($urandom_range(0, 1) == 1);
      er_e[k][e] = ($urandom_range(0, 1) == 1);
      rd_e[k][e] = $urandom;
      pd_e[k][e] = $urandom;
      if (pd_e[k][e] == 32'hDEAD_BEEF) pd_e[k][e] = 32'h1;
      wc_e[k][e] = 1'b0;
      exp_v[k][e] = pk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      exp_m[k][e] = M_FULL;
    end
    if (k == 0) pd_e[k][per] = 32'd2;
    reg_v = 32'h0; last_wd = 32'h0; s = per; j = 0; e_end = 0;
    while (s <= N) begin
      s0 = s; retries = 0; done = 1'b0;
      while (!done) begin
        wd = samp_at(k, per, s);
        ws = 0; wr = 0; werr = 1'b0; rerr = 1'b0; mode = 0;
        if (k == 0) begin
          case (j)
            0: ws = 0;
            1: ws = 3;
            2: werr = (retries == 0);
            3: begin mode = 1; ws = int'($urandom_range(0, 2)); wr = int'($urandom_range(0, 2)); end
            4: ws = 0;
            default: begin
              ws   = int'($urandom_range(0, 3));
              wr   = int'($urandom_range(0, 3));
              werr = ($urandom_range(0, 5) == 0);
              rerr = ($urandom_range(0, 5) == 0);
              mode = ($urandom_range(0, 5) == 0) ? 2 : 0;
            end
          endcase
        end else if (j == 0) begin
          ws = 6;
        end else begin
          ws   = int'($urandom_range(0, 4));
          wr   = int'($urandom_range(0, 4));
          werr = ($urandom_range(0, 4) == 0);
          rerr = ($urandom_range(0, 4) == 0);
          mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
        end
        // Write: setup at s, access from s+1, completes on edge cw.
        cw = s + 2 + ws;
        for (int e = s; e < cw; e++) begin
          exp_v[k][e] = pk(1'b1, e > s, 1'b1, addr, wd);
          exp_m[k][e] = M_FULL;
        end
        for (int e = s + 2; e < cw; e++) pr_e[k][e] = 1'b0;
        pr_e[k][cw] = 1'b1; er_e[k][cw] = werr; wc_e[k][cw] = 1'b1;
        last_wd = wd;
        if (werr) begin
          if (retries < maxr) begin retries++; s = cw; end
          else begin e_end = cw; done = 1'b1; end
        end else begin
          reg_v = wd;
          cr = cw + 2 + wr;
          for (int e = cw; e < cr; e++) begin
            exp_v[k][e] = pk(1'b1, e > cw, 1'b0, addr, wd);
            exp_m[k][e] = M_FULL;
          end
          for (int e = cw + 2; e < cr; e++) pr_e[k][e] = 1'b0;
          pr_e[k][cr] = 1'b1; er_e[k][cr] = rerr;
          case (mode)
            1:       rd = 32'hDEAD_BEEF;
            2:       rd = reg_v ^ (32'h1 << $urandom_range(0, 31));
            default: rd = reg_v;
          endcase
          rd_e[k][cr] = rd;
          if (!rerr && rd == samp_at(k, per, cr - 1)) begin e_end = cr; done = 1'b1; end
          else if (retries < maxr) begin retries++; s = cr; end
          else begin e_end = cr; done = 1'b1; end
        end
      end
      for (int e = e_end; e < NE; e++) begin
        exp_v[k][e] = pk(1'b0, 1'b0, 1'b0, 8'h00, last_wd);
        exp_m[k][e] = M_IDLE;
      end
      // Any tick while busy leaves one request pending; otherwise wait for the next tick.
      pend = ((e_end / per) * per) > s0;
      s = pend ? e_end + 1 : ((e_end / per) + 1) * per;
      j++;
    end
  endtask

  task automatic drive(input int e);
    s0_pdata = pd_e[0][e]; s0_prdata = rd_e[0][e]; s0_pready = pr_e[0][e]; s0_pslverr = er_e[0][e];
    s1_pdata = pd_e[1][e]; s1_prdata = rd_e[1][e]; s1_pready = pr_e[1][e]; s1_pslverr = er_e[1][e];
  endtask

  // Count write completions seen on the bus, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && s0_psel && s0_penable && s0_pwrite && s0_pready) obs_w0++;
    if (!rst && s1_psel && s1_penable && s1_pwrite && s1_pready) obs_w1++;
  end

  initial begin
    int rst_edge, mw0, mw1;
    rst = 1'b1;
    s0_pdata = '0; s0_prdata = '0; s0_pready = 1'b0; s0_pslverr = 1'b0;
    s1_pdata = '0; s1_prdata = '0; s1_pready = 1'b0; s1_pslverr = 1'b0;
    gen(0, P0, R0, A0);
    gen(1, P1, R1, A1);
    rst_edge = N;
    for (int e = N - 60; e <= N; e++) begin
      if (exp_v[0][e][42]) begin rst_edge = e; break; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset0", 64'(obs(0)), 64'(0));
    chk("reset1", 64'(obs(1)), 64'(0));

    drive(1);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= rst_edge; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("bus_i%0d_e%0d", k, e), 64'(obs(k) & exp_m[k][e]), 64'(exp_v[k][e] & exp_m[k][e]));
      if (e < rst_edge) drive(e + 1);
    end

    // Reset in the middle of a transfer must clear outputs before the next edge.
    #3 rst = 1'b1;
    #1;
    chk("async_rst0", 64'(obs(0)), 64'(0));
    chk("async_rst1", 64'(obs(1)), 64'(0));

    mw0 = 0; mw1 = 0;
    for (int e = 1; e <= rst_edge; e++) begin
      mw0 += int'(wc_e[0][e]);
      mw1 += int'(wc_e[1][e]);
    end
    chk("writes0", 64'(obs_w0), 64'(mw0));
    chk("writes1", 64'(obs_w1), 64'(mw1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_sampler.md
# apb_sampler

APB master that periodically captures a 32-bit input word and writes it to one APB slave register, then reads the register back to confirm the write. It sits between a free-running data source (`pdata_i`) and the peripheral bus. A small state machine retries on slave error or read-back mismatch. There are no status outputs.

## Interface
Parameters:
- `PERIOD`, default 50: sample interval in `pclk_i` cycles. Legal range is 2 or more.
- `ADDR`, default 8'h00: APB address of the target register.
- `MAX_RETRY`, default 2: extra write attempts allowed after the first one fails.

Ports:
- `pclk_i`, in, 1: single clock; all logic is on the rising edge.
- `preset_i`, in, 1: reset, asynchronous and active-high.
- `pdata_i`, in, 32: data word to sample.
- `prdata_i`, in, 32: APB read data.
- `pready_i`, in, 1: APB slave ready.
- `pslverr_i`, in, 1: APB slave error, valid when `pready_i`=1 in an access cycle.
- `psel_o`, out, 1: APB select.
- `penable_o`, out, 1: APB enable.
- `paddr_o`, out, 8: APB address.
- `pwdata_o`, out, 32: APB write data.
- `pwrite_o`, out, 1: 1 = write, 0 = read.

## Operation
- Period counter:
  - Width is clog2(`PERIOD`) bits. Reset value is 0.
  - Increments every cycle and wraps to 0 at `PERIOD`-1.
  - The tick is the edge where count = `PERIOD`-1.
- On a tick, `pdata_i` is latched into `sample_q`.
  - If the FSM is busy, a single `pending` bit is set instead, and `sample_q` is overwritten with the newest sample.
  - Further ticks while `pending` is set coalesce into it; they are not queued.
- FSM states: IDLE, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS.
  - IDLE: on a tick or on `pending`, go to W_SETUP. Clear `pending` and the retry count.
  - W_SETUP: go to W_ACCESS unconditionally.
  - W_ACCESS: hold while `pready_i`=0.
    - On `pready_i`=1 with `pslverr_i`=0, go to R_SETUP.
    - On `pready_i`=1 with `pslverr_i`=1, go to W_SETUP if retries < `MAX_RETRY` (increment retries); otherwise go to IDLE.
  - R_SETUP: go to R_ACCESS unconditionally.
  - R_ACCESS: hold while `pready_i`=0.
    - On `pready_i`=1 with `pslverr_i`=0 and `prdata_i`==`sample_q`, go to IDLE.
    - On a mismatch or `pslverr_i`=1, go to W_SETUP if retries < `MAX_RETRY` (increment retries); otherwise go to IDLE, and the sample is dropped.
- Bus outputs, all registered:
  - IDLE: `psel_o`=0, `penable_o`=0.
  - Setup states: `psel_o`=1, `penable_o`=0.
  - Access states: `psel_o`=1, `penable_o`=1.
  - `pwrite_o`=1 in W_* and 0 in R_*.
  - `paddr_o`=`ADDR` during every transfer.
  - `pwdata_o`=`sample_q` during write transfers. It holds its last value otherwise.
- Back-to-back transfers are allowed. Access goes directly to setup with `psel_o` staying high and `penable_o` dropping.
- `prdata_i` and `pslverr_i` are ignored outside an access cycle with `pready_i`=1.

## Timing
- Reset values: `psel_o`=0, `penable_o`=0, `pwrite_o`=0, `paddr_o`=8'h00, `pwdata_o`=0, counter=0, FSM=IDLE, `pending`=0, `sample_q`=0, retries=0.
- Reset asserted mid-transfer clears all outputs immediately, without waiting for a clock; the in-flight transfer is abandoned.
- After reset release, the first tick is on rising edge `PERIOD` (edge 50 by default).
- `psel_o` rises after the tick edge, so the setup cycle is the cycle following the tick.
- Minimum transaction with zero wait states is 4 cycles: W_SETUP, W_ACCESS, R_SETUP, R_ACCESS. The FSM returns to IDLE on the 4th edge after the tick.
- Each cycle of `pready_i`=0 in an access state adds one cycle. All outputs stay stable during wait states.
- A tick arriving on the same edge the FSM returns to IDLE sets `pending`. The next transaction starts one cycle later.

## Test plan
- Reset asserted with `pdata_i`=0 and `pready_i`=0 -> all outputs 0. Then assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Release reset, then `pdata_i`=2, `pready_i`=1, `prdata_i` mirrors the written data -> write to 8'h00 with `pwdata_o`=2 at edges 50-52, read at 52-54, IDLE at 54, next write at edge 100.
- `pready_i` held low for 3 cycles in W_ACCESS -> access extends 3 cycles. `psel_o`, `penable_o`, `paddr_o`, `pwdata_o` and `pwrite_o` stay stable throughout.
- `pslverr_i`=1 on the first write completion -> W_SETUP is re-entered with the same data. After a clean second write, the read-back completes.
- `prdata_i` stuck at 32'hDEAD_BEEF -> exactly 3 writes (1 + `MAX_RETRY`), then IDLE. The next period behaves normally.
- Set `PERIOD`=4 and `pready_i` low for 6 cycles -> overlapping ticks set a single `pending`. Exactly one follow-up transaction carries the latest `pdata_i`.
